reg_file_write_port: RTL
========================

Name: reg_file_write_port

Overview:
- Write side of the 32-entry register file; counterpart to the 32:1 read mux.
- Accepts write requests over a valid/ready handshake and buffers them in a small FIFO.
- Commits one request per cycle by decoding the 5-bit address into a one-hot enable and updating the selected register.
- Exposes all 32 registers as a flattened bus that feeds the read-mux data inputs (register i on bits [i*WIDTH +: WIDTH]).

Parameters:
- WIDTH, 32, data width of each register.
- SIZE, 5, address width; the register count is fixed at 32 (2**SIZE).
- DEPTH, 4, write-buffer entries; power of two, at least 2.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- wr_valid  input  1  write request present.
- wr_ready  output  1  buffer can accept a request.
- wr_addr  input  SIZE  destination register.
- wr_data  input  WIDTH  write data.
- commit_en  input  1  permits the FIFO head to be committed this cycle (low = stall).
- wr_en_onehot  output  32  registered one-hot of the register written at the last edge.
- regs_flat  output  32*WIDTH  contents of all registers.
- pending  output  $clog2(DEPTH+1)  number of buffered, uncommitted requests.
- busy  output  1  high when pending != 0.

Behaviour:
- Interface decision: one clock; reset is synchronous and active-high (reset sampled on the rising edge of clk).
- Reset:
  - All 32 registers are cleared to 0.
  - The FIFO is emptied: pending=0, busy=0, wr_ready=1.
  - wr_en_onehot is cleared to 0.
  - Reset takes priority over everything else; buffered writes are discarded.
- Accept: occurs at an edge where wr_valid && wr_ready; {wr_addr, wr_data} is pushed at the FIFO tail.
- wr_ready: combinational, equal to (pending < DEPTH).
  - No push-through when full, even if a pop occurs in the same cycle.
  - wr_ready does not depend on wr_valid.
- Commit: occurs at an edge where pending != 0 && commit_en.
  - The head entry is popped.
  - If head address != 0: reg[addr] <= data, and wr_en_onehot <= (1 << addr).
  - If head address == 0: the pop still happens, reg[0] stays 0, and wr_en_onehot <= 0.
- wr_en_onehot is 0 in every cycle that follows an edge with no commit; it is a single-cycle pulse per commit.
- Latency:
  - A request accepted at edge N is committed at edge N+1 at the earliest, given an empty FIFO and commit_en=1.
  - Its data appears on regs_flat in the cycle after edge N+1.
  - No bypass from wr_data to regs_flat.
- Order: strict FIFO; same-address writes land in acceptance order, so the last one wins.
- Simultaneous push and pop at the same edge: pending is unchanged; the pushed entry queues behind the remaining entries.
- pending update: +1 on push only, -1 on pop only, unchanged on both or neither; never exceeds DEPTH and never underflows.
- Pointers: read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- commit_en low: the FIFO holds; accepts continue until full.
- regs_flat: driven directly from the storage registers, with no combinational path from the inputs.
- Inputs wr_addr and wr_data are don't-care when wr_valid=0.

Test Plan:
- Reset, then write {addr=5, data=0xDEADBEEF} with commit_en=1 -> accepted at edge N; at edge N+1 wr_en_onehot=0x00000020 for one cycle; from then on regs_flat[5*32 +: 32]=0xDEADBEEF and all other registers are 0; pending returns to 0.
- Hold commit_en=0 and issue 5 back-to-back writes to addresses 1..5 -> first 4 accepted; pending=4, wr_ready=0, 5th held. Then raise commit_en -> addresses 1,2,3,4,5 commit on consecutive edges; the 5th is accepted the cycle after the first pop.
- Write addr 0, data 0xFFFFFFFF -> commit edge pops the entry; wr_en_onehot=0; reg0 stays 0; pending decrements.
- Write addr 7 with 0x11, then addr 7 with 0x22, back-to-back -> wr_en_onehot=0x80 on two consecutive cycles; final reg7=0x22.
- With pending=2 and commit_en=1, hold wr_valid=1 continuously -> pending stays 2 (simultaneous push/pop), and commits emerge in order with wraparound across 8+ writes.
- Fill 3 entries with reg 9 previously written as 0x55, then assert reset for 1 cycle -> pending=0, wr_en_onehot=0, all regs 0 including reg9; no buffered write commits after reset is released.

Source files
------------

// File: rtl/reg_file_write_port_if.sv
// Write-request handshake for the register-file write port.
// The master (producer) drives the request and the slave (write port) returns ready.
interface reg_file_write_port_if #(
  parameter int WIDTH = 32,
  parameter int SIZE  = 5
) ();
  logic             wr_valid;
  logic             wr_ready;
  logic [SIZE-1:0]  wr_addr;
  logic [WIDTH-1:0] wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/reg_file_write_port.sv
// Write side of the 32-entry register file: a small request FIFO drained one entry
// per cycle into the register array, which is exposed flat to the read mux.

module reg_file_cell #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             we_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] q_q;

  always_ff @(posedge clk_i) begin
    if (reset_i)   q_q <= '0;
    else if (we_i) q_q <= d_i;
  end

  assign q_o = q_q;
endmodule

module reg_file_write_port #(
  parameter int WIDTH = 32,
  parameter int SIZE  = 5,
  parameter int DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  reg_file_write_port_if.slave         wr,
  input  logic                         commit_en_i,
  output logic [31:0]                  wr_en_onehot_o,
  output logic [32*WIDTH-1:0]          regs_flat_o,
  output logic [$clog2(DEPTH+1)-1:0]   pending_o,
  output logic                         busy_o
);
  localparam int NREG  = 32;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  typedef struct packed {
    logic [SIZE-1:0]  addr;
    logic [WIDTH-1:0] data;
  } wr_req_t;

  wr_req_t                    fifo_q [DEPTH];
  logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [NREG-1:0]            we_d, wr_en_q;
  logic [NREG-1:0][WIDTH-1:0] regs;
  logic                       push, pop;
  wr_req_t                    head;

  // Ready depends only on occupancy, so a full FIFO refuses even when a pop is coming.
  assign wr.wr_ready = (cnt_q < CNT_W'(DEPTH));
  assign push        = wr.wr_valid && wr.wr_ready;
  assign pop         = (cnt_q != '0) && commit_en_i;
  assign head        = fifo_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    we_d     = '0;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      // Register 0 is hardwired: its entry is consumed but no enable fires.
      if (head.addr != '0) we_d[head.addr] = 1'b1;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      wr_en_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      wr_en_q  <= we_d;
    end
  end

  // Payload storage needs no reset; the pointer reset alone discards buffered entries.
  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q] <= {wr.wr_addr, wr.wr_data};
  end

  for (genvar i = 0; i < NREG; i++) begin : g_reg
    if (i == 0) begin : g_zero
      assign regs[i] = '0;
    end else begin : g_cell
      reg_file_cell #(.WIDTH(WIDTH)) u_cell (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .we_i    (we_d[i]),
        .d_i     (head.data),
        .q_o     (regs[i])
      );
    end
  end

  assign regs_flat_o    = regs;
  assign wr_en_onehot_o = wr_en_q;
  assign pending_o      = cnt_q;
  assign busy_o         = (cnt_q != '0);
endmodule
